bcp_round_ctrl: RTL and testbench
=================================

Name: bcp_round_ctrl

Overview:
- Sequences one bcp_pe through repeated BCP rounds over a clause buffer.
- Each round pops one literal from the unit-clause queue (UCQ) and streams every live clause through the PE at one clause per cycle.
- Surviving pruned clauses are compacted in place, and newly created unit literals are pushed back to the UCQ.
- Reports SAT, UNSAT or OPEN (needs a decision) to the top-level solver FSM.

Parameters:
- CLA_LENGTH, 3, literals per clause.
- LIT_W, 8, literal width; 2's complement, 0 means pruned/empty.
- NUM_CLA, 256, clause buffer depth.
- ADDR_W, $clog2(NUM_CLA), buffer address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin solve; ignored while busy
- num_cla  in  ADDR_W+1  initial live clause count, sampled on start
- ucq_empty  in  1  UCQ empty
- ucq_lit  in  LIT_W  UCQ head literal
- ucq_pop  out  1  pop UCQ head
- imply_push  out  1  push implied literal to UCQ
- imply_lit  out  LIT_W  implied literal
- imply_full  in  1  UCQ full
- rd_en  out  1  buffer read
- rd_addr  out  ADDR_W  read address
- rd_data  in  cla_t  read data; valid the cycle after rd_en, held stable until the next rd_en
- wr_en  out  1  buffer write
- wr_addr  out  ADDR_W  write address
- wr_data  out  cla_t  write data
- pe_lit  out  LIT_W  current round literal to PE
- pe_clause  out  cla_t  clause to PE (equals rd_data)
- pe_done, pe_conflict, pe_imply  in  1  PE results
- pe_imply_idx  in  LIT_W  PE unit literal
- pe_pr_clause  in  cla_t  PE pruned clause
- busy  out  1  not IDLE and not in a result state
- result_valid  out  1  result held
- result  out  2  1=SAT, 2=UNSAT, 3=OPEN
- live_cnt  out  ADDR_W+1  live clauses after the last completed round
- round_cnt  out  16  rounds completed, saturating

Behaviour:
- Reset: state IDLE. All outputs 0, except pe_clause = rd_data. live_cnt, round_cnt, rptr and wptr are 0. Reset mid-operation aborts immediately; no further wr_en, ucq_pop or imply_push.
- IDLE: on start, live_cnt <= num_cla, round_cnt <= 0, clear result_valid, go to CHECK.
- CHECK (1 cycle; lets last-cycle UCQ pushes become visible):
  - live_cnt==0 -> SAT.
  - else ucq_empty -> OPEN.
  - else POP.
- POP (1 cycle): ucq_pop=1, latch ucq_lit into lit_r, rptr=wptr=0, go to SCAN.
- pe_lit = lit_r at all times.
- SCAN:
  - rd_en issued for rptr while rptr<live_cnt and the previous clause is not stalled; rptr increments on issue.
  - A clause is "present" in the cycle after its rd_en.
  - A present clause is consumed this cycle unless stalled.
  - Stall condition: pe_imply && new-unit && imply_full, where new-unit means pe_pr_clause != rd_data. During a stall, rd_en=0 and rd_data is held.
  - Consuming rd_en and the next rd_en occur in the same cycle, giving 1 clause/cycle throughput.
- Consume actions, by PE result:
  - pe_conflict: no write; go to UNSAT.
  - pe_done: drop the clause (no write).
  - otherwise: wr_en=1, wr_addr=wptr, wr_data=pe_pr_clause, wptr++.
  - Additionally, if pe_imply && new-unit: imply_push=1, imply_lit=pe_imply_idx.
  - A clause already unit on entry is written back but not re-pushed.
- Write safety: wptr <= rptr always, so in-place compaction never overwrites an unread clause.
- Round end: when rptr==live_cnt and no clause is present, live_cnt <= wptr, round_cnt++ (saturating at 0xFFFF), go to CHECK.
- Result states SAT/UNSAT/OPEN:
  - result_valid=1 and result held; busy=0.
  - start re-enters IDLE flow next cycle; an OPEN result expects the solver to have pushed a decision into the UCQ.
- No assignment table is kept. Complementary implications surface as pe_conflict in a later round, because unit clauses are retained.
- live_cnt==0 at start: SAT two cycles after start.

Decomposition:
- bcp_pkg: CLA_LENGTH, LIT_W, lit_t, cla_t (CLA_LENGTH x lit_t), result encoding enum, FSM state enum.
- No sub-module: FSM, rptr/wptr and live_cnt stay in one module. bcp_pe is instantiated beside it at top level, not inside.

Test Plan:
- num_cla=0, start -> result=SAT, result_valid=1 two cycles later; round_cnt=0; no rd_en.
- Buffer {(1,2,0)}, UCQ={1} -> one ucq_pop, no wr_en, live_cnt=0, result=SAT, round_cnt=1.
- Buffer {(-1,2,0),(3,4,0)}, UCQ={1}:
  - Round 1: push 2; write (0,2,0)@0 and (3,4,0)@1.
  - Round 2: pops 2; writes (3,4,0)@0; live_cnt=1; UCQ empty -> OPEN; round_cnt=2.
- Buffer {(-1,0,0),(5,6,0)}, UCQ={1} -> pe_conflict on clause 0 -> UNSAT; no wr_en; clause 1 never consumed.
- Repeat the third scenario with imply_full high for 5 cycles at the first push:
  - rd_en low and rd_data stable throughout the stall.
  - Exactly one imply_push(2) after release.
  - Identical final buffer contents and OPEN result.
- Assert rst_n=0 mid-SCAN -> next cycle busy=0, result_valid=0, live_cnt=0, and no wr_en, ucq_pop or imply_push.

Source files
------------

// File: rtl/bcp_pkg.sv
// Shared types and constants for the BCP round controller and its processing element.
// The clause format is a packed array of signed literals, where 0 marks a pruned or empty slot.
package bcp_pkg;

  localparam int CLA_LENGTH = 3;
  localparam int LIT_W      = 8;
  localparam int NUM_CLA    = 256;
  localparam int ADDR_W     = $clog2(NUM_CLA);

  typedef logic signed [LIT_W-1:0] lit_t;
  typedef lit_t [CLA_LENGTH-1:0]   cla_t;

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_SAT   = 2'd1,
    RES_UNSAT = 2'd2,
    RES_OPEN  = 2'd3
  } result_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_POP,
    ST_SCAN,
    ST_SAT,
    ST_UNSAT,
    ST_OPEN
  } state_e;

  function automatic logic is_result(input state_e s);
    return (s == ST_SAT) || (s == ST_UNSAT) || (s == ST_OPEN);
  endfunction

endpackage

// File: rtl/bcp_round_ctrl.sv
// Sequences one external bcp_pe through repeated BCP rounds over the clause buffer.
// Live clauses are streamed at one clause per cycle and compacted in place.
module bcp_round_ctrl
  import bcp_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W:0]   num_cla_i,
  input  logic              ucq_empty_i,
  input  lit_t              ucq_lit_i,
  output logic              ucq_pop_o,
  output logic              imply_push_o,
  output lit_t              imply_lit_o,
  input  logic              imply_full_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  cla_t              rd_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output cla_t              wr_data_o,
  output lit_t              pe_lit_o,
  output cla_t              pe_clause_o,
  input  logic              pe_done_i,
  input  logic              pe_conflict_i,
  input  logic              pe_imply_i,
  input  lit_t              pe_imply_idx_i,
  input  cla_t              pe_pr_clause_i,
  output logic              busy_o,
  output logic              result_valid_o,
  output logic [1:0]        result_o,
  output logic [ADDR_W:0]   live_cnt_o,
  output logic [15:0]       round_cnt_o
);

  state_e            state_q, state_d;
  lit_t              lit_q, lit_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   live_q, live_d;
  logic [15:0]       round_q, round_d;
  logic              present_q, present_d;

  logic              pop, issue, write, push, stall, new_unit;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      lit_q     <= '0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      live_q    <= '0;
      round_q   <= '0;
      present_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lit_q     <= lit_d;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      live_q    <= live_d;
      round_q   <= round_d;
      present_q <= present_d;
    end
  end

  // A PE-pruned clause that differs from its input and is unit is a fresh implication.
  assign new_unit = pe_imply_i && (pe_pr_clause_i != rd_data_i);

  always_comb begin
    state_d   = state_q;
    lit_d     = lit_q;
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    live_d    = live_q;
    round_d   = round_q;
    present_d = present_q;
    pop       = 1'b0;
    issue     = 1'b0;
    write     = 1'b0;
    push      = 1'b0;
    stall     = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_SAT, ST_UNSAT, ST_OPEN: begin
        if (start_i) begin
          live_d  = num_cla_i;
          round_d = '0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (live_q == '0)     state_d = ST_SAT;
        else if (ucq_empty_i) state_d = ST_OPEN;
        else                  state_d = ST_POP;
      end
      ST_POP: begin
        pop       = 1'b1;
        lit_d     = ucq_lit_i;
        rptr_d    = '0;
        wptr_d    = '0;
        present_d = 1'b0;
        state_d   = ST_SCAN;
      end
      ST_SCAN: begin
        stall     = present_q && new_unit && imply_full_i;
        issue     = !stall && (rptr_q < live_q);
        present_d = stall || issue;
        if (issue) rptr_d = rptr_q + 1'b1;
        // Writes trail reads, so wptr never passes rptr and compaction is safe.
        if (present_q && !stall) begin
          if (pe_conflict_i) begin
            state_d = ST_UNSAT;
          end else begin
            if (!pe_done_i) begin
              write  = 1'b1;
              wptr_d = wptr_q + 1'b1;
            end
            push = new_unit;
          end
        end else if (!present_q && (rptr_q == live_q)) begin
          live_d  = wptr_q;
          round_d = (round_q == 16'hFFFF) ? round_q : round_q + 16'd1;
          state_d = ST_CHECK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are gated by reset so an abort takes effect in the same cycle.
  assign ucq_pop_o      = pop   && rst_ni;
  assign rd_en_o        = issue && rst_ni;
  assign wr_en_o        = write && rst_ni;
  assign imply_push_o   = push  && rst_ni;

  assign rd_addr_o      = rptr_q[ADDR_W-1:0];
  assign wr_addr_o      = wptr_q[ADDR_W-1:0];
  assign wr_data_o      = write ? pe_pr_clause_i : '0;
  assign imply_lit_o    = push ? pe_imply_idx_i : '0;

  assign pe_lit_o       = lit_q;
  assign pe_clause_o    = rd_data_i;

  assign busy_o         = (state_q != ST_IDLE) && !is_result(state_q);
  assign result_valid_o = is_result(state_q);
  assign result_o       = (state_q == ST_SAT)   ? RES_SAT   :
                          (state_q == ST_UNSAT) ? RES_UNSAT :
                          (state_q == ST_OPEN)  ? RES_OPEN  : RES_NONE;
  assign live_cnt_o     = live_q;
  assign round_cnt_o    = round_q;

endmodule

// File: tb/tb_bcp_round_ctrl.sv
// Directed bench for bcp_round_ctrl: behavioural PE, clause buffer and UCQ around the controller.
// Expected values are hand-derived from the BCP round semantics.
module tb_bcp_round_ctrl;
  import bcp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstN = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   numCla = '0;
  logic              ucqEmpty, ucqPop, implyPush, implyFull, rdEn, wrEn;
  lit_t              ucqLit, implyLit, peLit, peImplyIdx;
  logic [ADDR_W-1:0] rdAddr, wrAddr;
  cla_t              rdData = '0;
  cla_t              wrData, peClause, pePrClause;
  logic              peDone, peConflict, peImply;
  logic              busy, resultValid;
  logic [1:0]        result;
  logic [ADDR_W:0]   liveCnt;
  logic [15:0]       roundCnt;

  bcp_round_ctrl dut (
    .clk_i(clk), .rst_ni(rstN), .start_i(start), .num_cla_i(numCla),
    .ucq_empty_i(ucqEmpty), .ucq_lit_i(ucqLit), .ucq_pop_o(ucqPop),
    .imply_push_o(implyPush), .imply_lit_o(implyLit), .imply_full_i(implyFull),
    .rd_en_o(rdEn), .rd_addr_o(rdAddr), .rd_data_i(rdData),
    .wr_en_o(wrEn), .wr_addr_o(wrAddr), .wr_data_o(wrData),
    .pe_lit_o(peLit), .pe_clause_o(peClause),
    .pe_done_i(peDone), .pe_conflict_i(peConflict), .pe_imply_i(peImply),
    .pe_imply_idx_i(peImplyIdx), .pe_pr_clause_i(pePrClause),
    .busy_o(busy), .result_valid_o(resultValid), .result_o(result),
    .live_cnt_o(liveCnt), .round_cnt_o(roundCnt)
  );

  // Behavioural PE: satisfied clause -> done, else strip the negated literal and classify.
  lit_t negLit;
  int   nz;
  always_comb begin
    negLit     = -peLit;
    nz         = 0;
    peDone     = 1'b0;
    peConflict = 1'b0;
    peImply    = 1'b0;
    peImplyIdx = '0;
    pePrClause = peClause;
    for (int k = 0; k < CLA_LENGTH; k++)
      if (peLit != 0 && peClause[k] == peLit) peDone = 1'b1;
    if (!peDone) begin
      for (int k = 0; k < CLA_LENGTH; k++)
        if (peClause[k] == negLit) pePrClause[k] = '0;
      for (int k = 0; k < CLA_LENGTH; k++)
        if (pePrClause[k] != 0) begin
          nz++;
          peImplyIdx = pePrClause[k];
        end
      peConflict = (nz == 0);
      peImply    = (nz == 1);
      if (!peImply) peImplyIdx = '0;
    end
  end

  // Clause buffer and UCQ with preload ports driven by the stimulus.
  cla_t              mem [NUM_CLA];
  lit_t              ucqMem [16];
  logic [3:0]        ucqHead = '0, ucqTail = '0;
  logic [4:0]        ucqCount = '0;
  logic              tbMemWe = 1'b0, tbUcqPush = 1'b0, tbUcqClr = 1'b0, forceFull = 1'b0;
  logic [ADDR_W-1:0] tbMemAddr = '0;
  cla_t              tbMemData = '0;
  lit_t              tbUcqLit = '0;
  logic              pushNow, popNow;

  assign ucqEmpty  = (ucqCount == 0);
  assign ucqLit    = ucqMem[ucqHead];
  assign implyFull = forceFull || (ucqCount == 5'd16);
  assign pushNow   = tbUcqPush || implyPush;
  assign popNow    = ucqPop && (ucqCount != 0);

  always @(posedge clk) begin
    if (rdEn) rdData <= mem[rdAddr];
    if (tbMemWe)   mem[tbMemAddr] <= tbMemData;
    else if (wrEn) mem[wrAddr]    <= wrData;
    if (tbUcqClr) begin
      ucqHead  <= '0;
      ucqTail  <= '0;
      ucqCount <= '0;
    end else begin
      if (pushNow) begin
        ucqMem[ucqTail] <= tbUcqPush ? tbUcqLit : implyLit;
        ucqTail         <= ucqTail + 4'd1;
      end
      if (popNow) ucqHead <= ucqHead + 4'd1;
      if (pushNow && !popNow)      ucqCount <= ucqCount + 5'd1;
      else if (!pushNow && popNow) ucqCount <= ucqCount - 5'd1;
    end
  end

  // Event counters for pops, pushes, reads and writes.
  logic cntClr = 1'b0;
  int   wrCnt = 0, rdCnt = 0, popCnt = 0, pushCnt = 0;
  lit_t lastPush = '0;
  always @(posedge clk) begin
    if (cntClr) begin
      wrCnt <= 0; rdCnt <= 0; popCnt <= 0; pushCnt <= 0; lastPush <= '0;
    end else begin
      if (wrEn)   wrCnt  <= wrCnt + 1;
      if (rdEn)   rdCnt  <= rdCnt + 1;
      if (ucqPop) popCnt <= popCnt + 1;
      if (implyPush) begin
        pushCnt  <= pushCnt + 1;
        lastPush <= implyLit;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic cla_t mkCla(input int a, input int b, input int c);
    cla_t r;
    r[0] = lit_t'(a);
    r[1] = lit_t'(b);
    r[2] = lit_t'(c);
    return r;
  endfunction

  task automatic loadClause(input int addr, input cla_t c);
    @(negedge clk);
    tbMemWe = 1'b1; tbMemAddr = ADDR_W'(addr); tbMemData = c;
    @(negedge clk);
    tbMemWe = 1'b0;
  endtask

  task automatic loadUcq(input int l);
    @(negedge clk);
    tbUcqPush = 1'b1; tbUcqLit = lit_t'(l);
    @(negedge clk);
    tbUcqPush = 1'b0;
  endtask

  task automatic clearModels();
    @(negedge clk);
    cntClr = 1'b1; tbUcqClr = 1'b1;
    @(negedge clk);
    cntClr = 1'b0; tbUcqClr = 1'b0;
  endtask

  task automatic applyStimulus(input int n);
    @(negedge clk);
    numCla = (ADDR_W+1)'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitResult(input int budget);
    int n = 0;
    while (!resultValid && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("result_timeout", 32'(resultValid), 32'd1);
  endtask

  initial begin
    cla_t hold;
    int   n;
    int   snapWr, snapPop, snapPush;

    $display("[TB] reset");
    cntClr = 1'b1; tbUcqClr = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rv", 32'(resultValid), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_live", 32'(liveCnt), 32'd0);
    checkOutput("rst_round", 32'(roundCnt), 32'd0);
    checkOutput("rst_strobes", {28'd0, rdEn, wrEn, ucqPop, implyPush}, 32'd0);
    checkOutput("rst_pelit", 32'(peLit), 32'd0);
    checkOutput("rst_wrdata", 32'(wrData), 32'd0);
    rstN = 1'b1; cntClr = 1'b0; tbUcqClr = 1'b0;
    @(negedge clk);

    $display("[TB] empty clause set");
    applyStimulus(0);
    checkOutput("sat0_not_yet", 32'(resultValid), 32'd0);
    @(negedge clk);
    checkOutput("sat0_rv", 32'(resultValid), 32'd1);
    checkOutput("sat0_result", 32'(result), 32'd1);
    checkOutput("sat0_round", 32'(roundCnt), 32'd0);
    checkOutput("sat0_rdcnt", 32'(rdCnt), 32'd0);
    checkOutput("sat0_busy", 32'(busy), 32'd0);

    $display("[TB] single satisfied clause");
    clearModels();
    loadClause(0, mkCla(1, 2, 0));
    loadUcq(1);
    applyStimulus(1);
    waitResult(50);
    checkOutput("sat1_result", 32'(result), 32'd1);
    checkOutput("sat1_pop", 32'(popCnt), 32'd1);
    checkOutput("sat1_wr", 32'(wrCnt), 32'd0);
    checkOutput("sat1_live", 32'(liveCnt), 32'd0);
    checkOutput("sat1_round", 32'(roundCnt), 32'd1);

    $display("[TB] implication then open");
    clearModels();
    loadClause(0, mkCla(-1, 2, 0));
    loadClause(1, mkCla(3, 4, 0));
    loadUcq(1);
    applyStimulus(2);
    waitResult(80);
    checkOutput("open_result", 32'(result), 32'd3);
    checkOutput("open_live", 32'(liveCnt), 32'd1);
    checkOutput("open_round", 32'(roundCnt), 32'd2);
    checkOutput("open_pop", 32'(popCnt), 32'd2);
    checkOutput("open_push", 32'(pushCnt), 32'd1);
    checkOutput("open_pushlit", 32'(lastPush), 32'(lit_t'(2)));
    checkOutput("open_wr", 32'(wrCnt), 32'd3);
    checkOutput("open_mem0", 32'(mem[0]), 32'(mkCla(3, 4, 0)));
    checkOutput("open_mem1", 32'(mem[1]), 32'(mkCla(3, 4, 0)));
    checkOutput("open_ucq_empty", 32'(ucqEmpty), 32'd1);

    $display("[TB] conflict");
    clearModels();
    loadClause(0, mkCla(-1, 0, 0));
    loadClause(1, mkCla(5, 6, 0));
    loadUcq(1);
    applyStimulus(2);
    waitResult(50);
    checkOutput("unsat_result", 32'(result), 32'd2);
    checkOutput("unsat_wr", 32'(wrCnt), 32'd0);
    checkOutput("unsat_push", 32'(pushCnt), 32'd0);
    checkOutput("unsat_round", 32'(roundCnt), 32'd0);
    checkOutput("unsat_live", 32'(liveCnt), 32'd2);
    checkOutput("unsat_mem1", 32'(mem[1]), 32'(mkCla(5, 6, 0)));

    $display("[TB] implication with UCQ back-pressure");
    clearModels();
    loadClause(0, mkCla(-1, 2, 0));
    loadClause(1, mkCla(3, 4, 0));
    loadUcq(1);
    forceFull = 1'b1;
    applyStimulus(2);
    n = 0;
    while (!(busy && peImply && (pePrClause != rdData)) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stall_seen", 32'(busy && peImply && (pePrClause != rdData)), 32'd1);
    hold = rdData;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_rden", 32'(rdEn), 32'd0);
      checkOutput("stall_rddata", 32'(rdData), 32'(hold));
      checkOutput("stall_push", 32'(implyPush), 32'd0);
      checkOutput("stall_wr", 32'(wrEn), 32'd0);
      @(negedge clk);
    end
    forceFull = 1'b0;
    waitResult(80);
    checkOutput("bp_result", 32'(result), 32'd3);
    checkOutput("bp_push", 32'(pushCnt), 32'd1);
    checkOutput("bp_pushlit", 32'(lastPush), 32'(lit_t'(2)));
    checkOutput("bp_mem0", 32'(mem[0]), 32'(mkCla(3, 4, 0)));
    checkOutput("bp_mem1", 32'(mem[1]), 32'(mkCla(3, 4, 0)));
    checkOutput("bp_live", 32'(liveCnt), 32'd1);
    checkOutput("bp_round", 32'(roundCnt), 32'd2);

    $display("[TB] reset during scan");
    clearModels();
    loadClause(0, mkCla(7, 8, 0));
    loadClause(1, mkCla(9, 10, 0));
    loadClause(2, mkCla(11, 12, 0));
    loadClause(3, mkCla(13, 14, 0));
    loadUcq(1);
    applyStimulus(4);
    n = 0;
    while (!wrEn && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scan_write_seen", 32'(wrEn), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("abort_wr_now", 32'(wrEn), 32'd0);
    snapWr = wrCnt; snapPop = popCnt; snapPush = pushCnt;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_rv", 32'(resultValid), 32'd0);
    checkOutput("abort_live", 32'(liveCnt), 32'd0);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("abort_wrcnt", 32'(wrCnt), 32'(snapWr));
    checkOutput("abort_popcnt", 32'(popCnt), 32'(snapPop));
    checkOutput("abort_pushcnt", 32'(pushCnt), 32'(snapPush));
    checkOutput("abort_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
